// File: rtl/leiwand_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: valid/ready bus responder, TX FIFO, serializer.
// Optional level interrupt (CTRL.IRQ_EN, irq output) enabled by defining UART_TX_IRQ_EN.
module leiwand_uart_tx #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned DEFAULT_DIV = 867
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid,
  output logic               ready,
  input  logic [WIDTH-1:0]   addr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [WIDTH/8-1:0] wen,
  output logic [WIDTH-1:0]   rdata,
  output logic               tx,
  output logic               irq
);

  localparam int unsigned WB = WIDTH / 8;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic             r_ready;
  logic [WIDTH-1:0] r_rdata;
  logic [15:0]      r_div;
  logic             r_ovf;
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  state_t           r_state;
  logic             r_tx;
  logic [15:0]      r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_shift;

  logic             w_accept;
  logic             w_write;
  logic             w_read;
  logic [1:0]       w_sel;
  logic             w_full;
  logic             w_empty;
  logic             w_busy;
  logic             w_push_req;
  logic             w_push;
  logic             w_pop;
  logic             w_ovf_clr;
  logic [WIDTH-1:0] w_rdata;
  logic             w_unused;

  assign w_accept   = valid & ~r_ready;
  assign w_write    = |wen;
  assign w_read     = w_accept & ~w_write;
  assign w_sel      = addr[3:2];
  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_busy     = (r_state != S_IDLE);
  assign w_push_req = w_accept & w_write & (w_sel == 2'd0) & wen[0];
  assign w_push     = w_push_req & ~w_full;
  assign w_pop      = (r_state == S_IDLE) & ~w_empty;
  assign w_ovf_clr  = w_accept & w_write & (w_sel == 2'd1) & wen[0] & wdata[3];
  assign w_unused   = ^{addr[WIDTH-1:4], addr[1:0], wdata[WIDTH-1:16], wen[WB-1:2]};

`ifdef UART_TX_IRQ_EN
  logic r_irq_en;
  logic r_irq;

  // Level interrupt: FIFO drained and serializer idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_accept && w_write && (w_sel == 2'd3) && wen[0]) begin
        r_irq_en <= wdata[0];
      end
      r_irq <= r_irq_en & w_empty & ~w_busy;
    end
  end

  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

  // Register read mux, sampled into r_rdata on acceptance.
  always_comb begin
    w_rdata = '0;
    case (w_sel)
      2'd1: begin
        w_rdata[0]    = w_full;
        w_rdata[1]    = w_empty;
        w_rdata[2]    = w_busy;
        w_rdata[3]    = r_ovf;
        w_rdata[15:8] = 8'(r_count);
      end
      2'd2: w_rdata[15:0] = r_div;
`ifdef UART_TX_IRQ_EN
      2'd3: w_rdata[0] = r_irq_en;
`endif
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready <= 1'b0;
      r_rdata <= '0;
      r_div   <= 16'(DEFAULT_DIV);
      r_ovf   <= 1'b0;
    end else begin
      r_ready <= w_accept;
      r_rdata <= w_read ? w_rdata : '0;
      if (w_accept && (w_sel == 2'd2)) begin
        if (wen[0]) r_div[7:0]  <= wdata[7:0];
        if (wen[1]) r_div[15:8] <= wdata[15:8];
      end
      // A dropped push sets OVF even when a pop frees a slot this cycle.
      if (w_push_req && w_full) begin
        r_ovf <= 1'b1;
      end else if (w_ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= wdata[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Serializer; bit timer reloads from live BAUDDIV at every bit boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_tx    <= 1'b1;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift <= r_mem[r_rptr];
            r_cnt   <= r_div;
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (r_cnt == '0) begin
            r_cnt   <= r_div;
            r_idx   <= '0;
            r_tx    <= r_shift[0];
            r_shift <= {1'b0, r_shift[7:1]};
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt - 16'(1);
          end
        end
        S_DATA: begin
          if (r_cnt == '0) begin
            r_cnt <= r_div;
            if (r_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_idx   <= r_idx + 3'd1;
              r_tx    <= r_shift[0];
              r_shift <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_cnt <= r_cnt - 16'(1);
          end
        end
        S_STOP: begin
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 16'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign ready = r_ready;
  assign rdata = r_rdata;
  assign tx    = r_tx;

endmodule

// File: tb/tb_leiwand_uart_tx.sv
// Testbench for leiwand_uart_tx: register vector table, frame-decoding scoreboard,
// hand sequences for frame timing, overflow, async reset and interrupt.
module tb_leiwand_uart_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        ready;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wen = '0;
  logic [31:0] rdata;
  logic        tx;
  logic        irq;

  leiwand_uart_tx dut (
    .clk   (clk),
    .rst_n (rst_n),
    .valid (valid),
    .ready (ready),
    .addr  (addr),
    .wdata (wdata),
    .wen   (wen),
    .rdata (rdata),
    .tx    (tx),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks = 0;
  int          failures = 0;
  int unsigned tb_div = 867;
  logic        mon_en = 1'b0;
  int          frames_done = 0;
  logic [7:0]  exp_q[$];
  int unsigned start_q[$];
  int unsigned rdy_cyc;
  logic        irq_at_ready;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // One bus transfer; ready must appear exactly one clock after acceptance.
  task automatic bus(input logic [1:0] a, input logic [31:0] d, input logic [3:0] we,
                     output logic [31:0] rd);
    @(negedge clk);
    valid = 1'b1;
    addr  = {28'd0, a, 2'b00};
    wdata = d;
    wen   = we;
    @(posedge clk);
    #1;
    chk("ready_latency", {31'd0, ready}, 32'd1);
    rd           = rdata;
    rdy_cyc      = cyc;
    irq_at_ready = irq;
    valid = 1'b0;
    wen   = '0;
    @(posedge clk);
    #1;
    chk("ready_pulse", {31'd0, ready}, 32'd0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] we);
    logic [31:0] dummy;
    bus(a, d, we, dummy);
  endtask

  task automatic rd_chk(input string nm, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus(a, 32'd0, 4'd0, v);
    chk(nm, v, exp);
  endtask

  task automatic push(input logic [7:0] b, input logic expect_tx);
    if (expect_tx) exp_q.push_back(b);
    wr(2'd0, {24'd0, b}, 4'b0001);
  endtask

  task automatic set_div(input int unsigned d);
    wr(2'd2, d, 4'b0011);
    tb_div = d;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int t = 0;
    while (frames_done < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("frame_timeout", {31'd0, frames_done >= n}, 32'd1);
  endtask

  // Frame scoreboard: decodes 10 bit cells of tb_div+1 clocks, checks stability and value.
  int unsigned m_div;
  logic [9:0]  m_bits;
  logic        m_stable;
  logic [7:0]  m_exp;
  always begin
    @(negedge clk);
    if (mon_en && rst_n && tx === 1'b0) begin
      m_div    = tb_div;
      m_stable = 1'b1;
      start_q.push_back(cyc);
      for (int b = 0; b < 10; b++) begin
        for (int k = 0; k <= int'(m_div); k++) begin
          if (!(b == 0 && k == 0)) @(negedge clk);
          if (k == 0) m_bits[b] = tx;
          else if (tx !== m_bits[b]) m_stable = 1'b0;
        end
      end
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_frame got=0x%03h expected=no frame", m_bits);
      end else begin
        m_exp = exp_q.pop_front();
        chk("frame", {21'd0, m_stable, m_bits}, {21'd0, 1'b1, 1'b1, m_exp, 1'b0});
      end
      frames_done++;
    end
  end

  typedef struct {
    logic [1:0]  a;
    logic [31:0] d;
    logic [3:0]  we;
    logic [31:0] exp;
  } vec_t;

  localparam logic [31:0] CTRL_EXP =
`ifdef UART_TX_IRQ_EN
    32'd1;
`else
    32'd0;
`endif

  vec_t vecs[15];

  initial begin
    int unsigned r;
    int          base;

    vecs[0]  = '{2'd2, 32'd0,        4'b0000, 32'd867};
    vecs[1]  = '{2'd1, 32'd0,        4'b0000, 32'h0000_0002};
    vecs[2]  = '{2'd0, 32'd0,        4'b0000, 32'd0};
    vecs[3]  = '{2'd3, 32'd0,        4'b0000, 32'd0};
    vecs[4]  = '{2'd2, 32'h0000_00AB, 4'b0001, 32'd0};
    vecs[5]  = '{2'd2, 32'd0,        4'b0000, 32'h0000_03AB};
    vecs[6]  = '{2'd2, 32'h0000_1200, 4'b0010, 32'd0};
    vecs[7]  = '{2'd2, 32'd0,        4'b0000, 32'h0000_12AB};
    vecs[8]  = '{2'd2, 32'hFFFF_0003, 4'b0011, 32'd0};
    vecs[9]  = '{2'd2, 32'd0,        4'b0000, 32'h0000_0003};
    vecs[10] = '{2'd1, 32'hFFFF_FFFF, 4'b1111, 32'd0};
    vecs[11] = '{2'd1, 32'd0,        4'b0000, 32'h0000_0002};
    vecs[12] = '{2'd3, 32'h0000_0001, 4'b0001, 32'd0};
    vecs[13] = '{2'd3, 32'd0,        4'b0000, CTRL_EXP};
    vecs[14] = '{2'd3, 32'h0000_0000, 4'b0001, 32'd0};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_tx", {31'd0, tx}, 32'd1);
    mon_en = 1'b1;

    // Register access vectors
    for (int i = 0; i < 15; i++) begin
      logic [31:0] v;
      bus(vecs[i].a, vecs[i].d, vecs[i].we, v);
      if (vecs[i].we == 4'd0) chk($sformatf("vec%0d", i), v, vecs[i].exp);
    end
    tb_div = 3;

    // 0x55 at BAUDDIV=3, first frame starts one clock after ready
    start_q.delete();
    push(8'h55, 1'b1);
    r = rdy_cyc;
    wait_frames(1, 200);
    chk("first_start_latency", start_q[0] - r, 32'd1);
    repeat (2) @(negedge clk);
    rd_chk("status_after_55", 2'd1, 32'h0000_0002);
    chk("irq_idle", {31'd0, irq}, 32'd0);

    // Back-to-back frames at BAUDDIV=0: 10 clocks each, one idle clock between
    set_div(0);
    start_q.delete();
    base = frames_done;
    push(8'h01, 1'b1);
    push(8'h02, 1'b1);
    push(8'h03, 1'b1);
    wait_frames(base + 3, 200);
    chk("gap_1_2", start_q[1] - start_q[0], 32'd11);
    chk("gap_2_3", start_q[2] - start_q[1], 32'd11);

    // FIFO count decrements one per pop
    set_div(20);
    base = frames_done;
    push(8'hC1, 1'b1);
    push(8'hC2, 1'b1);
    push(8'hC3, 1'b1);
    push(8'hC4, 1'b1);
    rd_chk("count3", 2'd1, 32'h0000_0304);
    wait_frames(base + 1, 600);
    repeat (3) @(negedge clk);
    rd_chk("count2", 2'd1, 32'h0000_0204);
    wait_frames(base + 2, 600);
    repeat (3) @(negedge clk);
    rd_chk("count1", 2'd1, 32'h0000_0104);
    wait_frames(base + 4, 1200);
    repeat (3) @(negedge clk);
    rd_chk("count0", 2'd1, 32'h0000_0002);

    // Overflow: 1 popped, 8 stored, 10th dropped
    set_div(100);
    base = frames_done;
    for (int i = 0; i < 10; i++) push(8'(8'h30 + i), i < 9);
    rd_chk("ovf_status", 2'd1, 32'h0000_080D);
    wr(2'd1, 32'h0000_0008, 4'b0001);
    rd_chk("ovf_clear", 2'd1, 32'h0000_0805);
    wait_frames(base + 9, 12000);
    repeat (3) @(negedge clk);
    rd_chk("ovf_drained", 2'd1, 32'h0000_0002);

`ifdef UART_TX_IRQ_EN
    // Interrupt timing around a single frame at BAUDDIV=0
    set_div(0);
    wr(2'd3, 32'h0000_0001, 4'b0001);
    repeat (2) @(negedge clk);
    chk("irq_set_idle", {31'd0, irq}, 32'd1);
    push(8'h7E, 1'b1);
    r = rdy_cyc;
    chk("irq_at_ready", {31'd0, irq_at_ready}, 32'd1);
    chk("irq_fall", {31'd0, irq}, 32'd0);
    while (cyc < r + 11) @(negedge clk);
    chk("irq_low_idle_cycle", {31'd0, irq}, 32'd0);
    @(negedge clk);
    chk("irq_rise", {31'd0, irq}, 32'd1);
    wr(2'd3, 32'h0000_0000, 4'b0001);
    repeat (2) @(negedge clk);
    chk("irq_disabled", {31'd0, irq}, 32'd0);
`else
    chk("irq_tied_low", {31'd0, irq}, 32'd0);
`endif

    // Asynchronous reset during DATA bit 4 at BAUDDIV=3
    set_div(3);
    mon_en = 1'b0;
    push(8'hA5, 1'b0);
    r = rdy_cyc;
    push(8'h3C, 1'b0);
    while (cyc < r + 22) @(negedge clk);
    chk("bit4_before_reset", {31'd0, tx}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_tx_async", {31'd0, tx}, 32'd1);
    chk("reset_ready", {31'd0, ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    tb_div = 867;
    mon_en = 1'b1;
    rd_chk("reset_status", 2'd1, 32'h0000_0002);
    rd_chk("reset_div", 2'd2, 32'd867);
    repeat (40) @(negedge clk);
    chk("no_frame_after_reset", {31'd0, tx}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
